// File: rtl/mvm_result_collect_if.sv
// Result stream from the collector: one row word per accepted beat, valid/ready handshake.
// master drives the word and its index; slave returns ready.
interface mvm_result_collect_if #(
   parameter int logK = 5,
   parameter int b    = 8
);
   logic                  out_valid;
   logic                  out_ready;
   logic signed [2*b-1:0] out_data;
   logic [logK-1:0]       out_index;
   logic                  out_last;

   modport master (output out_valid, out_data, out_index, out_last, input out_ready);
   modport slave  (input out_valid, out_data, out_index, out_last, output out_ready);
endinterface

// File: rtl/mvm_result_collect.sv
// Buffers the K-word y readout that follows an mvm done pulse and replays it as an indexed stream.
// First word valid K edges after the done edge; stalls hold the word steady until out_ready accepts it.
module mvm_result_collect #(
   parameter int K    = 32,
   parameter int logK = 5,
   parameter int b    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  done,
   input  logic signed [2*b-1:0] data_in,
   input  logic                  flush,
   mvm_result_collect_if.master  res,
   output logic                  busy,
   output logic                  overrun
);
   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;
   localparam logic [logK-1:0] LAST = logK'(K - 1);

   state_t          state;
   logic [2*b-1:0]  buffer [K];
   logic [logK-1:0] cap_cnt;
   logic [logK-1:0] rd_cnt;
   logic [logK-1:0] rd_nxt;
   logic            valid_q;
   logic            last_q;
   logic [2*b-1:0]  data_q;
   logic            accept;
   logic            accept_last;

   assign rd_nxt      = rd_cnt + 1'b1;
   assign accept      = valid_q & res.out_ready;
   assign accept_last = accept & (rd_cnt == LAST);

   assign res.out_valid = valid_q;
   assign res.out_data  = data_q;
   assign res.out_index = rd_cnt;
   assign res.out_last  = last_q;

   // Storage carries no reset: valid_q only rises once all K entries of the batch are written.
   always_ff @(posedge clk) begin
      if (state == S_CAPTURE && !flush) begin
         buffer[cap_cnt] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         cap_cnt <= '0;
         rd_cnt  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
         busy    <= 1'b0;
         overrun <= 1'b0;
      end else if (flush) begin
         state   <= S_IDLE;
         rd_cnt  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (done) begin
                  state   <= S_CAPTURE;
                  cap_cnt <= '0;
                  busy    <= 1'b1;
               end
            end
            S_CAPTURE: begin
               if (done) overrun <= 1'b1;
               cap_cnt <= cap_cnt + 1'b1;
               if (cap_cnt == LAST) begin
                  state   <= S_DRAIN;
                  rd_cnt  <= '0;
                  valid_q <= 1'b1;
                  // With K==1 entry 0 is the word being written on this very edge.
                  data_q  <= (K == 1) ? data_in : buffer[0];
                  last_q  <= (LAST == '0);
               end
            end
            S_DRAIN: begin
               if (done && !accept_last) overrun <= 1'b1;
               if (accept_last) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  if (done) begin
                     state   <= S_CAPTURE;
                     cap_cnt <= '0;
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end else if (accept) begin
                  rd_cnt <= rd_nxt;
                  data_q <= buffer[rd_nxt];
                  last_q <= (rd_nxt == LAST);
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mvm_result_collect.sv
// Bench for mvm_result_collect: queue-based reference model checked every cycle plus directed literal checks.
module tb_mvm_result_collect;
   localparam int K = 32;

   logic               clk;
   logic               rst_n;
   logic               done;
   logic signed [15:0] data_in;
   logic               flush;
   logic               busy;
   logic               overrun;
   logic [15:0]        dut_data;

   int n_cmp = 0;
   int n_bad = 0;

   mvm_result_collect_if #(.logK(5), .b(8)) res ();

   mvm_result_collect #(.K(K), .logK(5), .b(8)) dut (
      .clk     (clk),
      .reset   (rst_n),
      .done    (done),
      .data_in (data_in),
      .flush   (flush),
      .res     (res.master),
      .busy    (busy),
      .overrun (overrun)
   );

   assign dut_data = res.out_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: words in flight as queues, not states.
   logic [15:0] cap_q[$];
   logic [15:0] out_q[$];
   int          cap_left;
   bit          m_overrun;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_q.delete();
         out_q.delete();
         cap_left  = 0;
         m_overrun = 1'b0;
      end else if (flush) begin
         cap_q.delete();
         out_q.delete();
         cap_left = 0;
      end else begin
         bit acc, acc_last, was_busy;
         acc      = (out_q.size() > 0) && res.out_ready;
         acc_last = acc && (out_q.size() == 1);
         was_busy = (cap_left > 0) || (out_q.size() > 0);
         if (acc) void'(out_q.pop_front());
         if (cap_left > 0) begin
            cap_q.push_back(data_in);
            cap_left--;
            if (cap_left == 0) out_q = cap_q;
         end
         if (done) begin
            if (!was_busy || acc_last) begin
               cap_left = K;
               cap_q.delete();
            end else begin
               m_overrun = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      bit mv;
      mv = out_q.size() > 0;
      chk("valid", res.out_valid, mv);
      chk("busy", busy, (cap_left > 0) || mv);
      chk("overrun", overrun, m_overrun);
      if (!rst_n) begin
         chk("rst_data", dut_data, 0);
         chk("rst_index", res.out_index, 0);
         chk("rst_last", res.out_last, 0);
      end else if (mv) begin
         chk("data", dut_data, out_q[0]);
         chk("index", res.out_index, K - out_q.size());
         chk("last", res.out_last, out_q.size() == 1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // kind 0: 100+n, kind 1: -1/-32768 then random, kind 2: random
   task automatic capture(input int kind, input int od_edge);
      for (int n = 1; n <= K; n++) begin
         if (kind == 0)                  data_in = 16'(100 + n);
         else if (kind == 1 && n == 1)   data_in = -16'sd1;
         else if (kind == 1 && n == 2)   data_in = -16'sd32768;
         else                            data_in = 16'($urandom);
         done = (n == od_edge);
         tick();
         if (n == od_edge) chk("overrun_set", overrun, 1);
      end
      done = 1'b0;
   endtask

   // pat 0: always ready, 1: 1,0,0,1 repeating, 2: random
   task automatic drain(input int pat, input bit b2b, input int rst_at);
      int c = 0;
      while ((res.out_valid || busy) && c < 400) begin
         if (pat == 0)      res.out_ready = 1'b1;
         else if (pat == 1) res.out_ready = (c % 4 == 0) || (c % 4 == 3);
         else               res.out_ready = 1'($urandom_range(0, 1));
         done = b2b && res.out_valid && (res.out_index == 5'(K - 1)) && res.out_ready;
         tick();
         c++;
         if (done) begin
            done = 1'b0;
            b2b  = 1'b0;
            chk("b2b_overrun", overrun, 0);
            chk("b2b_busy", busy, 1);
            chk("b2b_valid", res.out_valid, 0);
            capture(2, 0);
         end
         if (rst_at >= 0 && res.out_valid && res.out_index == 5'(rst_at)) begin
            #1 rst_n = 1'b0;
            #1;
            chk("arst_valid", res.out_valid, 0);
            chk("arst_busy", busy, 0);
            tick();
            tick();
            rst_n = 1'b1;
            tick();
            break;
         end
      end
      if (c >= 400) chk("drain_timeout", res.out_valid | busy, 0);
   endtask

   task automatic batch(input int pat, input int kind, input int od_edge, input bit b2b, input int rst_at);
      done = 1'b1;
      tick();
      done = 1'b0;
      capture(kind, od_edge);
      drain(pat, b2b, rst_at);
   endtask

   initial begin
      rst_n         = 1'b0;
      done          = 1'b0;
      flush         = 1'b0;
      data_in       = '0;
      res.out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_valid_lit", res.out_valid, 0);
      chk("rst_overrun_lit", overrun, 0);
      rst_n = 1'b1;
      tick();

      // Nominal: literal latency and word values
      done = 1'b1;
      tick();
      done = 1'b0;
      res.out_ready = 1'b1;
      for (int n = 1; n <= K; n++) begin
         data_in = 16'(100 + n);
         tick();
         if (n == K - 1) chk("lat_before", res.out_valid, 0);
      end
      chk("lat_first_valid", res.out_valid, 1);
      for (int i = 0; i < K; i++) begin
         if (i == 0 || i == K - 1) begin
            chk("nom_data_lit", dut_data, 16'(101 + i));
            chk("nom_index_lit", res.out_index, i);
            chk("nom_last_lit", res.out_last, i == K - 1);
         end
         if (i == K - 2) chk("nom_last_early", res.out_last, 0);
         tick();
      end
      chk("nom_end_valid", res.out_valid, 0);
      chk("nom_end_busy", busy, 0);

      batch(1, 0, 0, 1'b0, -1);

      // Negative words pass through bit-exact
      done = 1'b1;
      tick();
      done = 1'b0;
      res.out_ready = 1'b0;
      capture(1, 0);
      chk("neg0_lit", dut_data, 16'hFFFF);
      res.out_ready = 1'b1;
      tick();
      chk("neg1_lit", dut_data, 16'h8000);
      drain(2, 1'b0, -1);

      batch(2, 2, 10, 1'b0, -1);
      chk("overrun_sticky", overrun, 1);

      batch(0, 2, 0, 1'b1, 5);
      chk("overrun_cleared", overrun, 0);

      batch(0, 0, 0, 1'b1, -1);
      batch(2, 2, 0, 1'b0, -1);

      for (int i = 0; i < 1500; i++) begin
         done          = ($urandom_range(0, 15) == 0);
         flush         = ($urandom_range(0, 63) == 0);
         res.out_ready = ($urandom_range(0, 2) != 0);
         data_in       = 16'($urandom);
         tick();
      end
      done  = 1'b0;
      flush = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
